// File: rtl/complete_arbiter_if.sv
// Completion bus between the execution units, the completion arbiter and
// the ROB / wakeup network.
//   src_*   : four producer channels (0-2 = ALU0-2, 3 = LSU), valid/ready handshake
//   rob_*   : ROB acceptance for this cycle
//   wb0/wb1 : two registered completion ports
//   wake_*  : per-port ready broadcast towards the issue queues
// The master modport is the producer/consumer side; the slave modport is the arbiter.
interface complete_arbiter_if #(
  parameter int TAG_W = 4
);
  logic [3:0]         src_valid;
  logic [3:0]         src_ready;
  logic [127:0]       src_pc;
  logic [23:0]        src_dr;
  logic [127:0]       src_data;
  logic [4*TAG_W-1:0] src_rob;
  logic [3:0]         src_is_store;
  logic               rob_ready;

  logic               wb0_valid;
  logic [31:0]        wb0_pc;
  logic [5:0]         wb0_dr;
  logic [31:0]        wb0_data;
  logic [TAG_W-1:0]   wb0_rob;
  logic               wb0_is_store;

  logic               wb1_valid;
  logic [31:0]        wb1_pc;
  logic [5:0]         wb1_dr;
  logic [31:0]        wb1_data;
  logic [TAG_W-1:0]   wb1_rob;
  logic               wb1_is_store;

  logic [1:0]         wake_valid;
  logic [11:0]        wake_tag;

  modport master (
    output src_valid, src_pc, src_dr, src_data, src_rob, src_is_store, rob_ready,
    input  src_ready,
    input  wb0_valid, wb0_pc, wb0_dr, wb0_data, wb0_rob, wb0_is_store,
    input  wb1_valid, wb1_pc, wb1_dr, wb1_data, wb1_rob, wb1_is_store,
    input  wake_valid, wake_tag
  );

  modport slave (
    input  src_valid, src_pc, src_dr, src_data, src_rob, src_is_store, rob_ready,
    output src_ready,
    output wb0_valid, wb0_pc, wb0_dr, wb0_data, wb0_rob, wb0_is_store,
    output wb1_valid, wb1_pc, wb1_dr, wb1_data, wb1_rob, wb1_is_store,
    output wake_valid, wake_tag
  );
endinterface

// File: rtl/complete_arbiter.sv
// Completion arbiter: buffers results from four sources in per-source FIFOs
// and forwards up to two per cycle, round-robin, onto registered completion
// ports wb0/wb1, with a register-ready wakeup derived from those ports.
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset
//   bus : complete_arbiter_if slave (source channels, rob_ready, wb0/wb1, wake)
module complete_arbiter #(
  parameter int BUF_DEPTH = 2,
  parameter int TAG_W     = 4
) (
  input logic               clk,
  input logic               rst,
  complete_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]      pc;
    logic [5:0]       dr;
    logic [31:0]      data;
    logic [TAG_W-1:0] rob;
    logic             is_store;
  } entry_t;

  entry_t           mem [4][BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr [4];
  logic [PTR_W-1:0] rd_ptr [4];
  logic [CNT_W-1:0] count [4];
  logic [1:0]       rr_ptr;

  entry_t     in_e [4];
  logic [3:0] ready;
  logic [3:0] push;
  logic [3:0] pop;
  logic       g0_v, g1_v;
  logic [1:0] g0_i, g1_i;
  logic [1:0] idx;

  logic   wb0_v, wb1_v;
  entry_t wb0, wb1;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      in_e[i] = {bus.src_pc[32*i +: 32], bus.src_dr[6*i +: 6], bus.src_data[32*i +: 32],
                 bus.src_rob[TAG_W*i +: TAG_W], bus.src_is_store[i]};
      // Ready comes from the registered count only, so a full FIFO refuses
      // a push even in the cycle it is being popped.
      ready[i] = !rst && (count[i] < CNT_W'(BUF_DEPTH));
    end
  end

  assign push          = bus.src_valid & ready;
  assign bus.src_ready = ready;

  // Scan the four sources starting at rr_ptr; the first two non-empty ones win.
  always_comb begin
    g0_v = 1'b0;
    g0_i = 2'd0;
    g1_v = 1'b0;
    g1_i = 2'd0;
    idx  = 2'd0;
    pop  = 4'b0000;
    if (bus.rob_ready) begin
      for (int k = 0; k < 4; k++) begin
        idx = rr_ptr + 2'(k);
        if (count[idx] != '0) begin
          if (!g0_v) begin
            g0_v = 1'b1;
            g0_i = idx;
          end else if (!g1_v) begin
            g1_v = 1'b1;
            g1_i = idx;
          end
        end
      end
    end
    if (g0_v) pop[g0_i] = 1'b1;
    if (g1_v) pop[g1_i] = 1'b1;
  end

  // Storage carries no reset; occupancy is tracked by count/pointers alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_e[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr <= 2'd0;
      wb0_v  <= 1'b0;
      wb1_v  <= 1'b0;
      wb0    <= '0;
      wb1    <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
      if (bus.rob_ready) begin
        wb0_v <= g0_v;
        wb1_v <= g1_v;
        if (g0_v) wb0 <= mem[g0_i][rd_ptr[g0_i]];
        if (g1_v) wb1 <= mem[g1_i][rd_ptr[g1_i]];
        if (g1_v)      rr_ptr <= g1_i + 2'd1;
        else if (g0_v) rr_ptr <= g0_i + 2'd1;
      end
    end
  end

  assign bus.wb0_valid    = wb0_v;
  assign bus.wb0_pc       = wb0.pc;
  assign bus.wb0_dr       = wb0.dr;
  assign bus.wb0_data     = wb0.data;
  assign bus.wb0_rob      = wb0.rob;
  assign bus.wb0_is_store = wb0.is_store;
  assign bus.wb1_valid    = wb1_v;
  assign bus.wb1_pc       = wb1.pc;
  assign bus.wb1_dr       = wb1.dr;
  assign bus.wb1_data     = wb1.data;
  assign bus.wb1_rob      = wb1.rob;
  assign bus.wb1_is_store = wb1.is_store;

  // Stores and writes to p0 never wake anything; rst masks a stale wb register.
  assign bus.wake_valid[0] = !rst && wb0_v && !wb0.is_store && (wb0.dr != 6'd0);
  assign bus.wake_valid[1] = !rst && wb1_v && !wb1.is_store && (wb1.dr != 6'd0);
  assign bus.wake_tag      = {wb1.dr, wb0.dr};
endmodule

// File: tb/tb_complete_arbiter.sv
module tb_complete_arbiter;
  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  dr;
    logic [31:0] data;
    logic [3:0]  rob;
    logic        st;
  } ent_t;

  typedef struct {
    ent_t e;
    int   port;
    int   cyc;
  } exp_t;

  typedef struct packed {
    logic [3:0] mask;
    logic [3:0] stm;
    logic [1:0] o0, o1, o2, o3;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  logic rr_q = 1'b0;
  int   asserts = 0;
  int   fails = 0;
  exp_t sbq[$];
  vec_t tbl[10];

  complete_arbiter_if #(.TAG_W(4)) bus ();
  complete_arbiter #(.BUF_DEPTH(2), .TAG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rr_q <= bus.rob_ready;
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic ent_t mk(input int vid, input int s, input logic st);
    ent_t e;
    e.pc   = 32'h1000_0000 + 32'(vid * 16 + s);
    e.dr   = 6'(vid * 4 + s);
    e.data = 32'hD00D_0000 ^ 32'(vid * 256 + s);
    e.rob  = 4'(vid + s);
    e.st   = st;
    return e;
  endfunction

  task automatic drive_slot(input int s, input ent_t e);
    bus.src_pc[32*s +: 32]   = e.pc;
    bus.src_dr[6*s +: 6]     = e.dr;
    bus.src_data[32*s +: 32] = e.data;
    bus.src_rob[4*s +: 4]    = e.rob;
    bus.src_is_store[s]      = e.st;
  endtask

  task automatic expect_out(input ent_t e, input int port, input int at_cyc);
    exp_t x;
    x.e    = e;
    x.port = port;
    x.cyc  = at_cyc;
    sbq.push_back(x);
  endtask

  // Scoreboard side: every fresh load of a wb port is matched against the queue.
  task automatic check_out(input int p);
    exp_t x;
    ent_t a;
    logic wv;
    if (p == 0) a = {bus.wb0_pc, bus.wb0_dr, bus.wb0_data, bus.wb0_rob, bus.wb0_is_store};
    else        a = {bus.wb1_pc, bus.wb1_dr, bus.wb1_data, bus.wb1_rob, bus.wb1_is_store};
    if (sbq.size() == 0) begin
      asserts++;
      fails++;
      $display("FAIL unexpected_emission: port %0d got pc %0h, required no output (cycle %0d)", p, a.pc, cyc);
    end else begin
      x  = sbq.pop_front();
      wv = !x.e.st && (x.e.dr != 6'd0);
      check("wb_port", 64'(p), 64'(x.port));
      check("wb_cycle", 64'(cyc), 64'(x.cyc));
      check("wb_pc", 64'(a.pc), 64'(x.e.pc));
      check("wb_dr", 64'(a.dr), 64'(x.e.dr));
      check("wb_data", 64'(a.data), 64'(x.e.data));
      check("wb_rob", 64'(a.rob), 64'(x.e.rob));
      check("wb_is_store", 64'(a.st), 64'(x.e.st));
      check("wake_valid", 64'(bus.wake_valid[p]), 64'(wv));
      check("wake_tag", 64'(bus.wake_tag[6*p +: 6]), 64'(x.e.dr));
    end
  endtask

  always @(negedge clk) begin
    if (rr_q) begin
      if (bus.wb0_valid) check_out(0);
      if (bus.wb1_valid) check_out(1);
    end
  end

  task automatic run_vec(input int vid, input vec_t v);
    logic [1:0] ord[4];
    int n;
    ord[0] = v.o0;
    ord[1] = v.o1;
    ord[2] = v.o2;
    ord[3] = v.o3;
    n = $countones(v.mask);
    for (int s = 0; s < 4; s++) drive_slot(s, mk(vid, s, v.stm[s]));
    bus.src_valid = v.mask;
    for (int j = 0; j < n; j++)
      expect_out(mk(vid, int'(ord[j]), v.stm[ord[j]]), j % 2, cyc + 2 + j / 2);
    tick();
    bus.src_valid = 4'b0000;
    repeat (4) tick();
  endtask

  initial begin
    ent_t x, p0, p1, p2, r0, r1, r2;
    int c;

    // round-robin order worked out by hand, rr_ptr starting at 0 after reset
    tbl[0] = '{4'b1111, 4'b0000, 2'd0, 2'd1, 2'd2, 2'd3};
    tbl[1] = '{4'b0100, 4'b0000, 2'd2, 2'd0, 2'd0, 2'd0};
    tbl[2] = '{4'b0011, 4'b0000, 2'd0, 2'd1, 2'd0, 2'd0};
    tbl[3] = '{4'b1001, 4'b0001, 2'd3, 2'd0, 2'd0, 2'd0};
    tbl[4] = '{4'b1110, 4'b0100, 2'd1, 2'd2, 2'd3, 2'd0};
    tbl[5] = '{4'b1000, 4'b1000, 2'd3, 2'd0, 2'd0, 2'd0};
    tbl[6] = '{4'b0111, 4'b0000, 2'd0, 2'd1, 2'd2, 2'd0};
    tbl[7] = '{4'b1101, 4'b0000, 2'd3, 2'd0, 2'd2, 2'd0};
    tbl[8] = '{4'b0000, 4'b0000, 2'd0, 2'd0, 2'd0, 2'd0};
    tbl[9] = '{4'b1010, 4'b0010, 2'd3, 2'd1, 2'd0, 2'd0};

    bus.src_valid    = '0;
    bus.src_pc       = '0;
    bus.src_dr       = '0;
    bus.src_data     = '0;
    bus.src_rob      = '0;
    bus.src_is_store = '0;
    bus.rob_ready    = 1'b1;

    // reset state
    tick();
    tick();
    check("rst_src_ready", 64'(bus.src_ready), 64'(4'b0000));
    check("rst_wb0_valid", 64'(bus.wb0_valid), 64'd0);
    check("rst_wb1_valid", 64'(bus.wb1_valid), 64'd0);
    check("rst_wake_valid", 64'(bus.wake_valid), 64'd0);
    check("rst_wb0_pc", 64'(bus.wb0_pc), 64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_src_ready", 64'(bus.src_ready), 64'(4'b1111));

    for (int i = 0; i < 10; i++) run_vec(i, tbl[i]);

    // single completion with known payload
    x = '{pc: 32'h0000_4000, dr: 6'd5, data: 32'h0000_00A5, rob: 4'd3, st: 1'b0};
    drive_slot(0, x);
    bus.src_valid = 4'b0001;
    expect_out(x, 0, cyc + 2);
    tick();
    bus.src_valid = 4'b0000;
    tick();
    check("single_wb0_valid", 64'(bus.wb0_valid), 64'd1);
    check("single_wb0_dr", 64'(bus.wb0_dr), 64'd5);
    check("single_wb0_data", 64'(bus.wb0_data), 64'hA5);
    check("single_wb1_valid", 64'(bus.wb1_valid), 64'd0);
    check("single_wake_valid", 64'(bus.wake_valid), 64'(2'b01));
    check("single_wake_tag", 64'(bus.wake_tag[5:0]), 64'd5);
    repeat (3) tick();

    // store completion from the LSU
    x = '{pc: 32'h0000_5000, dr: 6'd9, data: 32'h1234_5678, rob: 4'd7, st: 1'b1};
    drive_slot(3, x);
    bus.src_valid = 4'b1000;
    expect_out(x, 0, cyc + 2);
    tick();
    bus.src_valid = 4'b0000;
    tick();
    check("store_wb0_valid", 64'(bus.wb0_valid), 64'd1);
    check("store_wb0_is_store", 64'(bus.wb0_is_store), 64'd1);
    check("store_wake_valid", 64'(bus.wake_valid), 64'd0);
    repeat (3) tick();

    // backpressure on source 0
    x  = '{pc: 32'h0000_6000, dr: 6'd12, data: 32'h0000_0C0C, rob: 4'd1, st: 1'b0};
    p0 = '{pc: 32'h0000_6010, dr: 6'd13, data: 32'h0000_0D0D, rob: 4'd2, st: 1'b0};
    p1 = '{pc: 32'h0000_6020, dr: 6'd14, data: 32'h0000_0E0E, rob: 4'd3, st: 1'b0};
    p2 = '{pc: 32'h0000_6030, dr: 6'd15, data: 32'h0000_0F0F, rob: 4'd4, st: 1'b0};
    drive_slot(0, x);
    bus.src_valid = 4'b0001;
    expect_out(x, 0, cyc + 2);
    tick();
    bus.src_valid = 4'b0000;
    tick();
    bus.rob_ready = 1'b0;
    drive_slot(0, p0);
    bus.src_valid = 4'b0001;
    tick();
    check("bp_ready_after_1", 64'(bus.src_ready[0]), 64'd1);
    check("bp_hold_valid_1", 64'(bus.wb0_valid), 64'd1);
    check("bp_hold_pc_1", 64'(bus.wb0_pc), 64'(x.pc));
    drive_slot(0, p1);
    tick();
    check("bp_ready_full", 64'(bus.src_ready[0]), 64'd0);
    drive_slot(0, p2);
    tick();
    check("bp_ready_still_full", 64'(bus.src_ready[0]), 64'd0);
    check("bp_hold_valid_2", 64'(bus.wb0_valid), 64'd1);
    check("bp_hold_pc_2", 64'(bus.wb0_pc), 64'(x.pc));
    bus.src_valid = 4'b0000;
    bus.rob_ready = 1'b1;
    expect_out(p0, 0, cyc + 1);
    expect_out(p1, 0, cyc + 2);
    repeat (4) tick();

    // full source 1 popped while a push is attempted
    p0 = '{pc: 32'h0000_7000, dr: 6'd20, data: 32'h0000_7070, rob: 4'd5, st: 1'b0};
    p1 = '{pc: 32'h0000_7010, dr: 6'd21, data: 32'h0000_7171, rob: 4'd6, st: 1'b0};
    p2 = '{pc: 32'h0000_7020, dr: 6'd22, data: 32'h0000_7272, rob: 4'd7, st: 1'b0};
    bus.rob_ready = 1'b0;
    drive_slot(1, p0);
    bus.src_valid = 4'b0010;
    tick();
    drive_slot(1, p1);
    tick();
    check("sc_full_ready", 64'(bus.src_ready[1]), 64'd0);
    bus.rob_ready = 1'b1;
    drive_slot(1, p2);
    expect_out(p0, 0, cyc + 1);
    expect_out(p1, 0, cyc + 2);
    tick();
    check("sc_ready_after_pop", 64'(bus.src_ready[1]), 64'd1);
    bus.src_valid = 4'b0000;
    tick();
    check("sc_ready_empty", 64'(bus.src_ready[1]), 64'd1);
    repeat (4) tick();

    // reset with two entries buffered in source 2
    r0 = '{pc: 32'h0000_8000, dr: 6'd7, data: 32'h0000_8080, rob: 4'd8, st: 1'b0};
    r1 = '{pc: 32'h0000_8010, dr: 6'd8, data: 32'h0000_8181, rob: 4'd9, st: 1'b0};
    r2 = '{pc: 32'h0000_8020, dr: 6'd9, data: 32'h0000_8282, rob: 4'd10, st: 1'b0};
    drive_slot(2, r0);
    bus.src_valid = 4'b0100;
    expect_out(r0, 0, cyc + 2);
    tick();
    bus.src_valid = 4'b0000;
    tick();
    bus.rob_ready = 1'b0;
    drive_slot(2, r1);
    bus.src_valid = 4'b0100;
    tick();
    drive_slot(2, r2);
    tick();
    bus.src_valid = 4'b0000;
    tick();
    check("pre_rst_wake_valid", 64'(bus.wake_valid), 64'(2'b01));
    rst = 1'b1;
    #1;
    check("in_rst_wake_valid", 64'(bus.wake_valid), 64'd0);
    check("in_rst_src_ready", 64'(bus.src_ready), 64'(4'b0000));
    tick();
    check("rst_mid_wb0_valid", 64'(bus.wb0_valid), 64'd0);
    check("rst_mid_wb1_valid", 64'(bus.wb1_valid), 64'd0);
    check("rst_mid_wb0_dr", 64'(bus.wb0_dr), 64'd0);
    rst = 1'b0;
    bus.rob_ready = 1'b1;
    tick();
    check("rst_mid_src_ready", 64'(bus.src_ready), 64'(4'b1111));
    repeat (4) tick();

    // rr_ptr restarts at 0: source 0 wins over source 3
    run_vec(20, '{4'b1001, 4'b0000, 2'd0, 2'd3, 2'd0, 2'd0});

    c = sbq.size();
    check("scoreboard_drained", 64'(c), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/complete_arbiter.md
COMPLETE_ARBITER -- requirements
Module: complete_arbiter

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 2, entries per source buffer (power of two, >=2).
REQ-002 SHALL have parameter TAG_W, default 4, ROB tag width.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset is synchronous and active-high.
REQ-005 SHALL have port src_valid, input, 4: per-source result valid; source 0-2 = ALU0-2, source 3 = LSU.
REQ-006 SHALL have port src_ready, output, 4: per-source accept.
REQ-007 SHALL have port src_pc, input, 128: 4x32 completing PC; source i at bits [32i+31:32i].
REQ-008 SHALL have port src_dr, input, 24: 4x6 physical dest reg.
REQ-009 SHALL have port src_data, input, 128: 4x32 result data.
REQ-010 SHALL have port src_rob, input, 4*TAG_W: ROB tag.
REQ-011 SHALL have port src_is_store, input, 4: store completion, no register write.
REQ-012 SHALL have port rob_ready, input, 1: ROB can take completions this cycle.
REQ-013 SHALL have ports wb0_valid/wb1_valid, output, 1 each: completion port valid.
REQ-014 SHALL have ports wbN_pc 32, wbN_dr 6, wbN_data 32, wbN_rob TAG_W, wbN_is_store 1, all outputs, N in {0,1}.
REQ-015 SHALL have port wake_valid, output, 2, and wake_tag, output, 12 (2x6): UIQ/ROB ready broadcast.

Function
REQ-016 SHALL keep one FIFO of BUF_DEPTH entries per source holding {pc, dr, data, rob, is_store}.
REQ-017 SHALL drive src_ready[i] = (count[i] < BUF_DEPTH) from registered count; forced 0 while rst=1.
REQ-018 SHALL push source i at an edge where src_valid[i] & src_ready[i]; payload ignored otherwise.
REQ-019 SHALL, at each edge with rob_ready=1, grant up to two non-empty FIFOs in round-robin order starting at rr_ptr; at most one pop per source per cycle.
REQ-020 SHALL load the first grant into wb0 and the second into wb1; with one grant wb1_valid=0; with none both valid=0.
REQ-021 SHALL, with rob_ready=0, hold all wb outputs unchanged and pop nothing; pushes continue.
REQ-022 SHALL advance rr_ptr to (last granted source + 1) mod 4; unchanged with no grant.
REQ-023 SHALL register all wb outputs; input accepted at edge k appears on wb at edge k+1 earliest (no bypass).
REQ-024 SHALL preserve per-source FIFO order; no ordering guarantee across sources.
REQ-025 SHALL allow same-cycle push and pop on one FIFO; count unchanged; full FIFO rejects push even if popping (src_ready registered).
REQ-026 SHALL wrap FIFO read/write pointers modulo BUF_DEPTH.
REQ-027 SHALL drive wake_valid[N] = wbN_valid & ~wbN_is_store & (wbN_dr != 0), wake_tag[6N+5:6N] = wbN_dr, combinationally from wb registers.
REQ-028 SHALL leave wbN_dr/data fields as captured for stores; consumers qualify by is_store.

Reset
REQ-029 SHALL on rst=1 at an edge clear all FIFO counts and pointers, rr_ptr=0, wb0/wb1 valid=0 and all wb fields 0.
REQ-030 SHALL discard buffered entries on reset mid-operation; src_ready returns to 4'b1111 the cycle after rst deasserts.
REQ-031 SHALL produce wake_valid=0 whenever rst is held.

Verification
REQ-032 Single: src_valid=4'b0001, dr=5, data=0xA5, rob=3 at edge k, rob_ready=1 -> wb0_valid=1, dr=5, data=0xA5 after edge k+1; wb1_valid=0; wake_valid=2'b01, wake_tag[5:0]=5.
REQ-033 Four-way: all sources valid in one cycle, rr_ptr=0 -> wb0=src0, wb1=src1 next cycle; src2, src3 following cycle; rr_ptr ends at 0.
REQ-034 Backpressure: rob_ready=0 with src0 pushing each cycle -> src_ready[0]=0 after BUF_DEPTH pushes; wb holds; rob_ready=1 drains in push order.
REQ-035 Store: src3 valid, is_store=1, dr=9 -> wb0_valid=1, wb0_is_store=1, wake_valid=0.
REQ-036 Reset mid-run: two entries buffered in src2, rst=1 one cycle -> wb valid 0, no later emission of those entries, src_ready=4'b1111 after.
REQ-037 Same-cycle: full src1 FIFO with push attempted during pop -> push rejected, count BUF_DEPTH-1 after edge.
